// File: rtl/shift_pkg.sv
// Shared definitions for the row_shifter block: FSM states, travel
// direction encoding and the default row width.
package shift_pkg;

  localparam int ROW_W_DEF = 8;

  localparam logic DIR_RIGHT = 1'b0;  // toward bit 0
  localparam logic DIR_LEFT  = 1'b1;  // toward bit ROW_W-1

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/row_shifter_if.sv
// Control/data bundle between the row_shifter and its game controller.
// The master drives the request side; the slave is the shifter itself.
interface row_shifter_if
  import shift_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int SKIP_W = 4
);

  logic              adjClkPulse;
  logic              start;
  logic [ROW_W-1:0]  initLoc;
  logic [ROW_W-1:0]  belowRow;
  logic [SKIP_W-1:0] skipCnt;
  logic              stopBtn;
  logic [ROW_W-1:0]  newBlockLoc;
  logic              busy;
  logic              placed;
  logic              miss;

  modport master (
    output adjClkPulse, start, initLoc, belowRow, skipCnt, stopBtn,
    input  newBlockLoc, busy, placed, miss
  );

  modport slave (
    input  adjClkPulse, start, initLoc, belowRow, skipCnt, stopBtn,
    output newBlockLoc, busy, placed, miss
  );

endinterface

// File: rtl/btn_edge_det.sv
// Rising-edge detector for a debounced level button; the pulse lasts as
// long as the first cycle the button is seen high after being low.
module btn_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/row_shifter.sv
// Moving-block row for a stacker game: bounces (or rotates when
// ROW_SHIFTER_WRAP_EN is defined) until stopped, then trims to the row below.
module row_shifter
  import shift_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int SKIP_W = 4
) (
  input logic         clk,
  input logic         rst,
  row_shifter_if.slave bus
);

  state_t            state;
  logic              dir;
  logic [SKIP_W-1:0] skip;
  logic [ROW_W-1:0]  loc;
  logic              busy_q;
  logic              placed_q;
  logic              miss_q;

  logic              stop_rise;
  logic              do_load;
  logic [ROW_W-1:0]  step_loc;
  logic              step_dir;
  logic [ROW_W-1:0]  trimmed;

  btn_edge_det u_stop (
    .clk   (clk),
    .rst   (rst),
    .level (bus.stopBtn),
    .rise  (stop_rise)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    step_loc = loc;
    step_dir = dir;
`ifdef ROW_SHIFTER_WRAP_EN
    step_loc = {loc[0], loc[ROW_W-1:1]};
    step_dir = DIR_RIGHT;
`else
    // Hitting a wall spends the step on turning around, never on losing a cell.
    if (dir == DIR_RIGHT) begin
      if (loc[0]) step_dir = DIR_LEFT;
      else        step_loc = loc >> 1;
    end else begin
      if (loc[ROW_W-1]) step_dir = DIR_RIGHT;
      else              step_loc = loc << 1;
    end
`endif
  end

  assign trimmed = loc & bus.belowRow;
  assign do_load = bus.start && (state != CHECK);

  // NOTE: all control state, including the outputs, is cleared on reset
  // so an abandoned block can never produce a late placed pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      loc      <= '0;
      dir      <= DIR_RIGHT;
      skip     <= '0;
      busy_q   <= 1'b0;
      placed_q <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      placed_q <= 1'b0;
      if (do_load) begin
        loc    <= bus.initLoc;
        dir    <= DIR_RIGHT;
        skip   <= '0;
        miss_q <= 1'b0;
        busy_q <= 1'b1;
        state  <= (bus.initLoc == '0) ? CHECK : SHIFT;
      end else begin
        unique case (state)
          SHIFT: begin
            if (stop_rise) begin
              state <= CHECK;
            end else if (bus.adjClkPulse) begin
              if (skip == bus.skipCnt) begin
                loc  <= step_loc;
                dir  <= step_dir;
                skip <= '0;
              end else begin
                skip <= skip + 1'b1;
              end
            end
          end
          CHECK: begin
            loc      <= trimmed;
            placed_q <= 1'b1;
            miss_q   <= ~|trimmed;
            busy_q   <= 1'b0;
            state    <= DONE;
          end
          default: ;  // IDLE and DONE hold until the next start
        endcase
      end
    end
  end

  assign bus.newBlockLoc = loc;
  assign bus.busy        = busy_q;
  assign bus.placed      = placed_q;
  assign bus.miss        = miss_q;

endmodule

// File: tb/tb_row_shifter.sv
// Scoreboard bench for row_shifter: a block-position model predicts every
// cycle and queues each expected settle for an independent placed monitor.
module tb_row_shifter;

  localparam int ROW_W  = 8;
  localparam int SKIP_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  row_shifter_if #(.ROW_W(ROW_W), .SKIP_W(SKIP_W)) bus ();

  row_shifter #(.ROW_W(ROW_W), .SKIP_W(SKIP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_placed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus for the next cycle
  logic              d_rst = 1'b0, d_start = 1'b0, d_tick = 1'b0, d_btn = 1'b0;
  int                d_lo = 0, d_n = 0;
  logic [ROW_W-1:0]  d_below = '0;
  logic [SKIP_W-1:0] d_skip = '0;

  // Reference model: block is n contiguous cells starting at cell lo.
  typedef enum {M_IDLE, M_MOVE, M_SETTLE, M_HOLD} mode_t;
  mode_t            m_mode = M_IDLE;
  int               m_lo = 0, m_n = 0, m_step = -1, m_wait = 0;
  logic             m_btn_prev = 1'b0;
  logic [ROW_W-1:0] m_loc = '0;
  logic             m_miss = 1'b0, m_placed = 1'b0;

  typedef struct {
    logic [ROW_W-1:0] loc;
    logic             miss;
  } place_t;
  place_t sb[$];

  function automatic logic [ROW_W-1:0] block(input int lo, input int n);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[(lo + i) % ROW_W] = 1'b1;
    return r;
  endfunction

  task automatic model_move();
`ifdef ROW_SHIFTER_WRAP_EN
    m_lo = (m_lo + ROW_W - 1) % ROW_W;
`else
    if (m_step < 0) begin
      if (m_lo == 0) m_step = 1;
      else           m_lo--;
    end else begin
      if (m_lo + m_n == ROW_W) m_step = -1;
      else                     m_lo++;
    end
`endif
    m_loc = block(m_lo, m_n);
  endtask

  task automatic model_step();
    logic rise;
    rise       = d_btn && !m_btn_prev;
    m_btn_prev = d_rst ? 1'b0 : d_btn;
    m_placed   = 1'b0;
    if (d_rst) begin
      m_mode = M_IDLE; m_loc = '0; m_miss = 1'b0; m_step = -1; m_wait = 0;
    end else if (d_start && m_mode != M_SETTLE) begin
      m_lo = d_lo; m_n = d_n; m_loc = block(d_lo, d_n);
      m_step = -1; m_wait = 0; m_miss = 1'b0;
      m_mode = (d_n == 0) ? M_SETTLE : M_MOVE;
    end else begin
      case (m_mode)
        M_MOVE: begin
          if (rise) m_mode = M_SETTLE;
          else if (d_tick) begin
            if (m_wait == int'(d_skip)) begin
              m_wait = 0;
              model_move();
            end else begin
              m_wait = (m_wait + 1) % (1 << SKIP_W);
            end
          end
        end
        M_SETTLE: begin
          m_loc    = m_loc & d_below;
          m_miss   = (m_loc == '0);
          m_placed = 1'b1;
          sb.push_back('{loc: m_loc, miss: m_miss});
          m_mode   = M_HOLD;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    rst             = d_rst;
    bus.start       = d_start;
    bus.initLoc     = block(d_lo, d_n);
    bus.adjClkPulse = d_tick;
    bus.stopBtn     = d_btn;
    bus.belowRow    = d_below;
    bus.skipCnt     = d_skip;
    model_step();
    @(posedge clk);
    #1;
    check("loc",    bus.newBlockLoc, m_loc);
    check("busy",   bus.busy, (m_mode == M_MOVE || m_mode == M_SETTLE));
    check("miss",   bus.miss, m_miss);
    check("placed", bus.placed, m_placed);
    d_start = 1'b0;
    d_tick  = 1'b0;
    d_rst   = 1'b0;
  endtask

  task automatic go(input int lo, input int n);
    d_start = 1'b1; d_lo = lo; d_n = n;
    cycle();
  endtask

  task automatic ticks(input int k);
    repeat (k) begin
      d_tick = 1'b1;
      cycle();
    end
  endtask

  task automatic idle(input int k);
    repeat (k) cycle();
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a settled block.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.placed === 1'b1) begin
        n_placed++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: placed pulse with loc 0x%0h, none expected at %0t",
                   bus.newBlockLoc, $time);
        end else begin
          place_t e;
          e = sb.pop_front();
          check("sb_loc",  bus.newBlockLoc, e.loc);
          check("sb_miss", bus.miss, e.miss);
        end
      end
    end
  end

  initial begin
    int p0;
    rst = 1'b1; bus.start = 1'b0; bus.initLoc = '0; bus.adjClkPulse = 1'b0;
    bus.stopBtn = 1'b0; bus.belowRow = '0; bus.skipCnt = '0;

    d_rst = 1'b1; cycle();
    d_rst = 1'b1; cycle();

    // Bounce off the right wall from 0x07, then off the left wall
    d_skip = '0;
    go(0, 3);
`ifndef ROW_SHIFTER_WRAP_EN
    ticks(1); check("bounce_turn_right_wall", bus.newBlockLoc, 8'h07);
    ticks(1); check("bounce_first_left",      bus.newBlockLoc, 8'h0E);
    ticks(4); check("bounce_reach_left",      bus.newBlockLoc, 8'hE0);
    ticks(1); check("bounce_turn_left_wall",  bus.newBlockLoc, 8'hE0);
    ticks(1); check("bounce_back_right",      bus.newBlockLoc, 8'h70);
`else
    ticks(8);
`endif

    // Partial overlap: 0x38 on 0x1C settles to 0x18, placed two clocks after the edge
    go(3, 3);
    d_below = 8'h1C; d_btn = 1'b1;
    cycle();
    check("stop_edge_busy", bus.busy, 1'b1);
    cycle();
    check("partial_loc",    bus.newBlockLoc, 8'h18);
    check("partial_placed", bus.placed, 1'b1);
    check("partial_miss",   bus.miss, 1'b0);
    d_btn = 1'b0; idle(2);

    // No overlap: 0xC0 on 0x03 is a miss
    go(6, 2);
    d_below = 8'h03; d_btn = 1'b1;
    idle(2);
    check("miss_loc",  bus.newBlockLoc, 8'h00);
    check("miss_flag", bus.miss, 1'b1);
    d_btn = 1'b0; idle(2);

    // Held button across a restart settles only once
    p0 = n_placed;
    d_below = 8'hFF;
    go(2, 2);
    d_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 6) begin d_start = 1'b1; d_lo = 4; d_n = 2; end
      d_tick = i[0];
      cycle();
    end
    check("held_btn_one_place", n_placed - p0, 1);
    check("held_btn_still_busy", bus.busy, 1'b1);
    d_btn = 1'b0; cycle();

    // Stop and tick in the same cycle: no shift
    go(3, 2);
    d_btn = 1'b1; d_tick = 1'b1;
    cycle();
    check("stop_beats_tick", bus.newBlockLoc, 8'h18);
    cycle();
    d_btn = 1'b0; idle(2);

    // skipCnt=3: one shift per four ticks, then reset mid-shift
    d_skip = 4'd3;
    go(5, 2);
    ticks(3); check("skip_hold",  bus.newBlockLoc, 8'h60);
    ticks(1); check("skip_shift", bus.newBlockLoc, 8'h30);
    ticks(6);
    p0 = n_placed;
    d_rst = 1'b1; cycle();
    idle(3);
    check("rst_no_place", n_placed - p0, 0);
    check("rst_loc",      bus.newBlockLoc, 8'h00);

    // Empty initial pattern settles at once as a miss
    go(0, 0);
    cycle();
    check("empty_miss", bus.miss, 1'b1);
    idle(1);

`ifdef ROW_SHIFTER_WRAP_EN
    d_skip = '0;
    go(0, 2);
    ticks(1); check("wrap_first",  bus.newBlockLoc, 8'h81);
    ticks(1); check("wrap_second", bus.newBlockLoc, 8'hC0);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        d_start = 1'b1;
        d_n     = (r == 0) ? 0 : int'($urandom_range(1, ROW_W));
        d_lo    = int'($urandom_range(0, ROW_W - d_n));
        d_skip  = SKIP_W'($urandom_range(0, 2));
      end
      if (r == 99) d_rst = 1'b1;
      if ($urandom_range(0, 19) == 0) d_btn = ~d_btn;
      d_tick  = 1'($urandom_range(0, 1));
      d_below = ROW_W'($urandom);
      cycle();
    end

    d_btn = 1'b0;
    idle(4);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
